// File: rtl/wfunc_pkg.sv
// Shared types and constants for the windowing datapath.
// Complex sample layouts, lane component indices and saturation limits.
package wfunc_pkg;

  localparam int RE = 0;
  localparam int IM = 1;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  localparam logic [4:0] SHIFT_LIM = 5'd16;

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } complex32;

  typedef struct packed {
    logic signed [31:0] im;
    logic signed [31:0] re;
  } complex64;

  function automatic logic [4:0] clamp_shift(input logic [4:0] s);
    return (s > SHIFT_LIM) ? SHIFT_LIM : s;
  endfunction

endpackage

// File: rtl/win_scaler_rnd_sat.sv
// One 32-to-16 round/shift/saturate slice.
// Stage 1 registers the rounded, shifted value; stage 2 saturates it.
module rnd_sat
  import wfunc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] x,
  input  logic [4:0]  sh,
  output logic [15:0] y,
  output logic        sat
);

  localparam logic signed [32:0] HI = 33'sd32767;
  localparam logic signed [32:0] LO = -33'sd32768;

  logic signed [32:0] xs;
  logic signed [32:0] rnd;
  logic signed [32:0] sum;
  logic signed [32:0] s1;
  logic               hi;
  logic               lo;

  // 33 bits leave headroom so the rounding add cannot wrap
  always_comb begin
    xs  = {x[31], x};
    rnd = '0;
    if (sh != 5'd0)
      rnd = 33'sd1 <<< (sh - 5'd1);
    sum = (xs + rnd) >>> sh;
  end

  assign hi = (s1 > HI);
  assign lo = (s1 < LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      y   <= '0;
      sat <= 1'b0;
    end else if (en) begin
      s1  <= sum;
      sat <= hi | lo;
      unique case (1'b1)
        hi:      y <= SAT_MAX;
        lo:      y <= SAT_MIN;
        default: y <= s1[15:0];
      endcase
    end
  end

endmodule

// File: rtl/win_scaler.sv
// Window product scaler: rounds, shifts and saturates 32-bit lanes to 16 bits.
// Holds the APB registers, packet beat counter and stream handshake.
module win_scaler
  import wfunc_pkg::*;
#(
  parameter int FFT_SIZE = 8192,
  parameter int BUS_NUM  = 2,
  parameter int APB_AW   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  input  logic                           in_tlast,
  input  logic [BUS_NUM-1:0][1:0][31:0]  in_tdata,
  output logic                           out_tvalid,
  input  logic                           out_tready,
  output logic                           out_tlast,
  output logic [BUS_NUM-1:0][1:0][15:0]  out_tdata,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [APB_AW-1:0]              paddr,
  input  logic [31:0]                    pwdata,
  output logic [31:0]                    prdata
);

  localparam int N  = FFT_SIZE / BUS_NUM;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  logic                   en;
  logic                   in_fire;
  logic                   out_fire;
  logic                   flush_pulse;
  logic                   ctrl_wr;
  logic                   clr;
  logic [4:0]             shift;
  logic [4:0]             act_sh;
  logic [4:0]             cur_sh;
  logic [CW-1:0]          cnt;
  logic                   at_last;
  logic                   len_set;
  logic [15:0]            sat_cnt;
  logic                   len_err;
  logic                   busy;
  logic                   v1;
  logic                   last1;
  logic [2*BUS_NUM-1:0]   sat_vec;
  logic                   any_sat;
  logic                   unused;

  assign en        = out_tready | ~out_tvalid;
  assign in_tready = en & ~flush_pulse;
  assign in_fire   = in_tvalid & in_tready;
  assign out_fire  = out_tvalid & out_tready;

  assign ctrl_wr = psel & ~penable & pwrite & ~paddr[2];
  assign clr     = ctrl_wr & pwdata[8];

  assign at_last = (cnt == LAST_BEAT);
  assign busy    = (cnt != '0);
  assign any_sat = |sat_vec;

  // beat 0 picks up a fresh shift; the rest of the packet reuses it
  assign cur_sh = (cnt == '0) ? clamp_shift(shift) : act_sh;

  assign len_set = in_fire & (in_tlast ^ at_last);

  assign prdata = paddr[2]
    ? {14'd0, busy, len_err, sat_cnt}
    : {27'd0, shift};

  assign unused = ^{pwdata, paddr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift       <= '0;
      flush_pulse <= 1'b0;
    end else begin
      flush_pulse <= ctrl_wr & pwdata[16];
      if (ctrl_wr)
        shift <= pwdata[4:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
      len_err <= 1'b0;
    end else if (clr) begin
      sat_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (out_fire && any_sat && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
      if (len_set)
        len_err <= 1'b1;
    end
  end

  // an early in_tlast resyncs the counter so the next beat starts a packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      act_sh <= '0;
    end else if (flush_pulse) begin
      cnt <= '0;
    end else if (in_fire) begin
      if (cnt == '0)
        act_sh <= cur_sh;
      if (in_tlast || at_last)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      last1      <= 1'b0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (flush_pulse) begin
      v1         <= 1'b0;
      last1      <= 1'b0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (en) begin
      v1         <= in_fire;
      last1      <= in_fire & at_last;
      out_tvalid <= v1;
      out_tlast  <= v1 & last1;
    end
  end

  for (genvar l = 0; l < BUS_NUM; l++) begin : g_lane
    for (genvar c = 0; c < 2; c++) begin : g_comp
      rnd_sat u_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .x     (in_tdata[l][c]),
        .sh    (cur_sh),
        .y     (out_tdata[l][c]),
        .sat   (sat_vec[2*l+c])
      );
    end
  end

endmodule

// File: tb/tb_win_scaler.sv
// Scoreboard bench for win_scaler with FFT_SIZE=16, BUS_NUM=2 (8 beats).
// Tasks drive scenarios; a forked monitor compares outputs against the queue.
module tb_win_scaler;

  localparam int N = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_tvalid;
  logic                    in_tready;
  logic                    in_tlast;
  logic [1:0][1:0][31:0]   in_tdata;
  logic                    out_tvalid;
  logic                    out_tready = 1'b1;
  logic                    out_tlast;
  logic [1:0][1:0][15:0]   out_tdata;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [2:0]              paddr;
  logic [31:0]             pwdata;
  logic [31:0]             prdata;

  typedef struct {
    logic [1:0][1:0][15:0] d;
    logic                  last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   rdy_mode = 1;
  int   m_shift = 0;
  int   m_act = 0;
  int   m_cnt = 0;
  int   m_sat = 0;

  win_scaler #(.FFT_SIZE(16), .BUS_NUM(2), .APB_AW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tvalid  (in_tvalid),
    .in_tready  (in_tready),
    .in_tlast   (in_tlast),
    .in_tdata   (in_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .out_tdata  (out_tdata),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_tready = 1'b0;
      1:       out_tready = 1'b1;
      default: out_tready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic logic [15:0] rs(input logic [31:0] x, input int s,
                                     output bit sat);
    longint v;
    v = longint'($signed(x));
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    sat = 1'b0;
    if (v > 32767) begin sat = 1'b1; return 16'h7FFF; end
    if (v < -32768) begin sat = 1'b1; return 16'h8000; end
    return 16'(v);
  endfunction

  task automatic monitor();
    exp_t e;
    logic [1:0][1:0][15:0] hd;
    logic hl;
    bit hc = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) hc = 0;
      else begin
        if (hc) begin
          checks++;
          if (out_tvalid !== 1'b1 || out_tdata !== hd || out_tlast !== hl) begin
            errors++;
            $display("FAIL hold: got v=%b d=%h l=%b want d=%h l=%b",
                     out_tvalid, out_tdata, out_tlast, hd, hl);
          end
        end
        if (out_tvalid === 1'b1 && out_tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: got d=%h want none", out_tdata);
          end else begin
            e = q.pop_front();
            if (out_tdata !== e.d || out_tlast !== e.last) begin
              errors++;
              $display("FAIL beat: got d=%h l=%b want d=%h l=%b",
                       out_tdata, out_tlast, e.d, e.last);
            end
          end
        end
        hc = (out_tvalid === 1'b1) && !out_tready;
        hd = out_tdata;
        hl = out_tlast;
      end
    end
  endtask

  task automatic apb_wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
    if (a[2] == 1'b0) begin
      m_shift = int'(d[4:0]);
      if (d[8]) m_sat = 0;
    end
  endtask

  task automatic apb_rd(input logic [2:0] a, output logic [31:0] d);
    paddr = a;
    #1;
    d = prdata;
  endtask

  task automatic send(input logic [1:0][1:0][31:0] d, input logic last);
    exp_t e;
    bit s, anys, done;
    int eff;
    in_tdata = d; in_tlast = last; in_tvalid = 1;
    done = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (in_tready) begin
        done = 1;
        eff = (m_cnt == 0) ? ((m_shift > 16) ? 16 : m_shift) : m_act;
        if (m_cnt == 0) m_act = eff;
        e.last = (m_cnt == N - 1);
        anys = 0;
        for (int l = 0; l < 2; l++)
          for (int c = 0; c < 2; c++) begin
            e.d[l][c] = rs(d[l][c], eff, s);
            anys |= s;
          end
        if (last || m_cnt == N - 1) m_cnt = 0;
        else m_cnt++;
        if (mon_en) begin
          q.push_back(e);
          if (anys && m_sat < 16'hFFFF) m_sat++;
        end
      end
      @(posedge clk); #1;
    end
    in_tvalid = 0; in_tlast = 0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_tready stayed 0, want 1");
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d beats pending want 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (3) @(posedge clk); #1;
    checks += 4;
    if (in_tready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", in_tready); end
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_tvalid); end
    if (out_tlast !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_tlast); end
    if (out_tdata !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_tdata); end
    rst_n = 1;
    @(posedge clk); #1;
    checks += 3;
    if (in_tready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b want 1", in_tready); end
    apb_rd(3'h4, r);
    if (r !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", r); end
    apb_rd(3'h0, r);
    if (r !== 32'h0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", r); end
    mon_en = 1;
  endtask

  task automatic test_round();
    logic [1:0][1:0][31:0] d;
    logic [31:0] r;
    apb_wr(3'h0, 32'h0000_010F);
    for (int i = 0; i < N; i++) begin
      d = '0;
      d[0][0] = (i == 0) ? 32'h0000_4000 : 32'(i) * 32'h8000;
      d[1][1] = 32'hFFFF_C000;
      send(d, i == N - 1);
    end
    wait_drain();
    apb_rd(3'h4, r);
    checks++;
    if (r[15:0] !== 16'd0) begin errors++; $display("FAIL round_satcnt: got %0d want 0", r[15:0]); end
  endtask

  task automatic test_sat();
    logic [1:0][1:0][31:0] d;
    logic [31:0] r;
    apb_wr(3'h0, 32'h0000_0100);
    for (int i = 0; i < N; i++) begin
      d = {4{32'(i * 7)}};
      if (i == 0) begin
        d[0][0] = 32'h0001_0000;
        d[0][1] = 32'hFFFE_0000;
      end
      send(d, i == N - 1);
    end
    wait_drain();
    apb_rd(3'h4, r);
    checks++;
    if (r[15:0] !== 16'd1) begin errors++; $display("FAIL sat_cnt: got %0d want 1", r[15:0]); end
  endtask

  task automatic test_tlast();
    logic [31:0] r;
    apb_wr(3'h0, 32'h0000_0102);
    for (int i = 0; i < N; i++) send({4{32'(i * 100 + 3)}}, i == N - 1);
    wait_drain();
    apb_rd(3'h4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL tlast_status: got %h want 0", r); end
  endtask

  task automatic test_len_err();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) send({4{32'(i * 40)}}, i == 3);
    wait_drain();
    apb_rd(3'h4, r);
    checks += 2;
    if (r[16] !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b want 1", r[16]); end
    if (r[17] !== 1'b0) begin errors++; $display("FAIL len_resync_busy: got %b want 0", r[17]); end
    for (int i = 0; i < N; i++) send({4{32'(i * 9 + 1)}}, i == N - 1);
    wait_drain();
    apb_rd(3'h4, r);
    checks++;
    if (r[16] !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %b want 1", r[16]); end
    apb_wr(3'h0, 32'h0000_0102);
    apb_rd(3'h4, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL clr_status: got %h want 0", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r;
    logic [1:0][1:0][31:0] d;
    apb_wr(3'h0, 32'h0000_0106);
    rdy_mode = 2;
    for (int i = 0; i < 3 * N; i++) begin
      for (int k = 0; k < 4; k++) d[k/2][k%2] = $urandom;
      send(d, (i % N) == N - 1);
    end
    wait_drain();
    rdy_mode = 1;
    apb_rd(3'h4, r);
    checks++;
    if (r[15:0] !== 16'(m_sat)) begin errors++; $display("FAIL bp_satcnt: got %0d want %0d", r[15:0], m_sat); end
  endtask

  task automatic test_shift_change();
    logic [31:0] r;
    apb_wr(3'h0, 32'h0000_0104);
    for (int i = 0; i < 3; i++) send({4{32'h0001_2345 + 32'(i) * 32'h111}}, 1'b0);
    apb_wr(3'h0, 32'h0000_0008);
    apb_rd(3'h0, r);
    checks++;
    if (r !== 32'h8) begin errors++; $display("FAIL ctrl_rb: got %h want 8", r); end
    for (int i = 3; i < N; i++) send({4{32'h0001_2345 + 32'(i) * 32'h111}}, i == N - 1);
    for (int i = 0; i < N; i++) send({4{32'h0001_2345 + 32'(i) * 32'h111}}, i == N - 1);
    apb_wr(3'h0, 32'h0000_001F);
    for (int i = 0; i < N; i++) send({4{32'h7FFF_0000 - 32'(i) * 32'h1234_5678}}, i == N - 1);
    wait_drain();
  endtask

  task automatic test_flush();
    logic [31:0] r;
    mon_en = 0;
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        send({4{32'h100}}, 1'b0);
        send({4{32'h200}}, 1'b0);
        apb_rd(3'h4, r);
        checks++;
        if (r[17] !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b want 1", r[17]); end
      end else begin
        rdy_mode = 1;
        repeat (3) @(posedge clk); #1;
      end
      psel = 1; penable = 0; pwrite = 1; paddr = 3'h0; pwdata = 32'h0001_0004;
      @(posedge clk); #1;
      penable = 1;
      checks++;
      if (in_tready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_tready); end
      @(posedge clk); #1;
      psel = 0; penable = 0; pwrite = 0;
      checks += 3;
      if (out_tvalid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_tvalid); end
      if (out_tlast !== 1'b0) begin errors++; $display("FAIL flush_last: got %b want 0", out_tlast); end
      apb_rd(3'h4, r);
      if (r[17] !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", r[17]); end
    end
    m_shift = 4; m_cnt = 0;
    q.delete();
    mon_en = 1;
    rdy_mode = 1;
    for (int i = 0; i < N; i++) send({4{32'(i * 333 + 5)}}, i == N - 1);
    wait_drain();
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    mon_en = 0;
    apb_wr(3'h0, 32'h0000_0005);
    rdy_mode = 0;
    @(posedge clk); #1;
    send({4{32'h1000}}, 1'b0);
    send({4{32'h2000}}, 1'b0);
    #2 rst_n = 0;
    #1;
    checks += 2;
    if (out_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", out_tvalid); end
    if (in_tready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", in_tready); end
    rdy_mode = 1;
    @(posedge clk); #1;
    rst_n = 1;
    m_shift = 0; m_act = 0; m_cnt = 0; m_sat = 0;
    q.delete();
    @(posedge clk); #1;
    checks += 2;
    apb_rd(3'h4, r);
    if (r !== 32'h0) begin errors++; $display("FAIL midrst_status: got %h want 0", r); end
    apb_rd(3'h0, r);
    if (r !== 32'h0) begin errors++; $display("FAIL midrst_ctrl: got %h want 0", r); end
    mon_en = 1;
    for (int i = 0; i < N; i++) send({4{32'(i * 3)}}, i == N - 1);
    wait_drain();
  endtask

  initial begin
    rst_n = 0;
    in_tvalid = 0; in_tlast = 0; in_tdata = '0;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_round();
    test_sat();
    test_tlast();
    test_len_err();
    test_backpressure();
    test_shift_change();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
